bus_cycle_sequencer: RTL and testbench



---
 rtl/bus_cycle_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: 68030 bus cycle sequencer that sits between address decode
// and the CPU bus pins. It counts per-device wait states or waits for an external
// acknowledge, drives DSACK1/DSACK0 for the latched port width, raises BERR for
// unmapped cycles, and owns the sticky boot vector_fetched flag.
// Optional feature macro: BUS_TIMEOUT_EN (abort stalled cycles with BERR after
// TIMEOUT_CYCLES clocks in WAIT/EXTWAIT).
module bus_cycle_sequencer #(
    parameter int          NUM_DEVICES    = 16,
    parameter logic [63:0] WAIT_STATES    = 64'h0000_0000_0000_0000,
    parameter logic [15:0] EXT_ACK_MASK   = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          VECTOR_CYCLES  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       as,
    input  logic [3:0] device_index,
    input  logic [1:0] port_width,
    input  logic       ext_ack,
    output logic [1:0] dsack_n,
    output logic       berr_n,
    output logic       vector_fetched,
    output logic       cycle_active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_EXTWAIT,
        S_ACK,
        S_ERROR
    } state_t;

    localparam int VW = $clog2(VECTOR_CYCLES + 1);

    state_t          state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic [1:0]      width_q, width_d;
    logic            armed_q, armed_d;
    logic [VW-1:0]   vector_cnt_q, vector_cnt_d;
    logic            vector_fetched_q, vector_fetched_d;
    logic [1:0]      dsack_n_q, dsack_n_d;
    logic            berr_n_q, berr_n_d;
    logic            cycle_active_q, cycle_active_d;
    logic            unmapped;
    logic            timed_out;

    // A cycle that decodes to the null device, a null port or an index past the
    // populated device range can never be acknowledged, so it goes to ERROR.
    assign unmapped = (device_index == 4'd0) || (port_width == 2'd0) ||
                      (int'(device_index) >= NUM_DEVICES);

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;

    assign timed_out = (timeout_cnt_q == TW'(TIMEOUT_CYCLES));

    // Timeout counter: zero outside the stall states, counts every edge a cycle stays stalled.
    always_comb begin
        timeout_cnt_d = '0;
        if ((state_q == S_WAIT || state_q == S_EXTWAIT) && state_d == state_q) begin
            timeout_cnt_d = timeout_cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            timeout_cnt_q <= '0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // Next state, counters and the registered-output values derived from the next state.
    always_comb begin
        state_d          = state_q;
        wait_cnt_d       = wait_cnt_q;
        width_d          = width_q;
        armed_d          = armed_q | ~as;
        vector_cnt_d     = vector_cnt_q;
        vector_fetched_d = vector_fetched_q;

        case (state_q)
            S_IDLE: begin
                // A new cycle needs an as=0 sample since reset or the last cycle,
                // so a strobe left high across reset cannot start a cycle.
                if (as && armed_q) begin
                    armed_d = 1'b0;
                    width_d = port_width;
                    if (unmapped) begin
                        state_d = S_ERROR;
                    end else if (EXT_ACK_MASK[device_index]) begin
                        state_d = S_EXTWAIT;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_STATES[{device_index, 2'b00} +: 4];
                    end
                end
            end
            S_WAIT: begin
                if (!as) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = 4'd0;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else if (timed_out) begin
                    state_d    = S_ERROR;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_EXTWAIT: begin
                // ext_ack is checked before the timeout so a coincident acknowledge wins.
                if (!as) begin
                    state_d = S_IDLE;
                end else if (ext_ack) begin
                    state_d = S_ACK;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_ACK, S_ERROR: begin
                if (!as) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Boot vector fetch: count acknowledged cycles until the vector is complete.
        if (state_d == S_ACK && state_q != S_ACK && !vector_fetched_q) begin
            vector_cnt_d = vector_cnt_q + 1'b1;
            if (vector_cnt_d == VW'(VECTOR_CYCLES)) begin
                vector_fetched_d = 1'b1;
            end
        end

        dsack_n_d = 2'b11;
        if (state_d == S_ACK) begin
            case (width_d)
                2'd1:    dsack_n_d = 2'b10;
                2'd2:    dsack_n_d = 2'b01;
                2'd3:    dsack_n_d = 2'b00;
                default: dsack_n_d = 2'b11;
            endcase
        end
        berr_n_d       = (state_d != S_ERROR);
        cycle_active_d = (state_d != S_IDLE);
    end

    // State, counters and registered bus outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            wait_cnt_q       <= 4'd0;
            width_q          <= 2'd0;
            armed_q          <= 1'b0;
            vector_cnt_q     <= '0;
            vector_fetched_q <= 1'b0;
            dsack_n_q        <= 2'b11;
            berr_n_q         <= 1'b1;
            cycle_active_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            wait_cnt_q       <= wait_cnt_d;
            width_q          <= width_d;
            armed_q          <= armed_d;
            vector_cnt_q     <= vector_cnt_d;
            vector_fetched_q <= vector_fetched_d;
            dsack_n_q        <= dsack_n_d;
            berr_n_q         <= berr_n_d;
            cycle_active_q   <= cycle_active_d;
        end
    end

    assign dsack_n        = dsack_n_q;
    assign berr_n         = berr_n_q;
    assign vector_fetched = vector_fetched_q;
    assign cycle_active   = cycle_active_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Testbench for bus_cycle_sequencer: table-driven bus cycles, randomized cycles
// checked against a transaction-level model, and a reset-during-ACK sequence.
module tb_bus_cycle_sequencer;

    // Wait states per device, nibble i = device i (dev15 .. dev0 from the left).
    localparam logic [63:0] WS_P  = 64'h1296_0431_F027_5000;
    localparam logic [15:0] EXT_P = 16'h0844;   // devices 2, 6, 11 use ext_ack
    localparam int          VEC   = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       as;
    logic [3:0] device_index;
    logic [1:0] port_width;
    logic       ext_ack;
    logic [1:0] dsack_n;
    logic       berr_n;
    logic       vector_fetched;
    logic       cycle_active;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state for the boot vector flag.
    int vcnt_exp = 0;
    bit vf_exp   = 1'b0;

    bus_cycle_sequencer #(
        .NUM_DEVICES    (16),
        .WAIT_STATES    (WS_P),
        .EXT_ACK_MASK   (EXT_P),
        .TIMEOUT_CYCLES (255),
        .VECTOR_CYCLES  (VEC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .as             (as),
        .device_index   (device_index),
        .port_width     (port_width),
        .ext_ack        (ext_ack),
        .dsack_n        (dsack_n),
        .berr_n         (berr_n),
        .vector_fetched (vector_fetched),
        .cycle_active   (cycle_active)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] dev;
        logic [1:0] pw;
        int         hold;   // edges with as=1, edge 0 is the sampling edge
        int         ext_d;  // edge on which ext_ack is sampled (0 = not an ext device)
        int         ack_e;  // edge of first dsack assertion
        logic [1:0] ds;     // expected dsack_n once acknowledged
        bit         err;    // cycle expected to end in BERR
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input int e, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %b want %b", nm, e, act, exp);
        end
    endtask

    function automatic int ws_of(input logic [3:0] d);
        logic [63:0] w;
        w = WS_P;
        return int'(w[{d, 2'b00} +: 4]);
    endfunction

    function automatic logic [1:0] code_of(input logic [1:0] pw);
        case (pw)
            2'd1:    return 2'b10;
            2'd2:    return 2'b01;
            2'd3:    return 2'b00;
            default: return 2'b11;
        endcase
    endfunction

    // Runs one bus cycle; called #1 after a posedge with as=0.
    task automatic run_cycle(input string nm, input vec_t v);
        as           = 1'b1;
        device_index = v.dev;
        port_width   = v.pw;
        ext_ack      = 1'b0;
        for (int e = 0; e < v.hold; e++) begin
            @(posedge clock);
            #1;
            if (!v.err && e == v.ack_e && !vf_exp) begin
                vcnt_exp++;
                if (vcnt_exp == VEC) vf_exp = 1'b1;
            end
            chk({nm, " active"}, e, {1'b0, cycle_active}, 2'b01);
            chk({nm, " berr_n"}, e, {1'b0, berr_n}, {1'b0, !v.err});
            chk({nm, " dsack_n"}, e, dsack_n, (!v.err && e >= v.ack_e) ? v.ds : 2'b11);
            chk({nm, " vector_fetched"}, e, {1'b0, vector_fetched}, {1'b0, vf_exp});
            // Decode inputs are latched; scrambling them must not matter.
            device_index = 4'($urandom);
            port_width   = 2'($urandom);
            if (v.ext_d > 0) ext_ack = (e + 1 == v.ext_d);
            else             ext_ack = 1'($urandom);
        end
        as = 1'b0;
        @(posedge clock);
        #1;
        chk({nm, " end active"}, v.hold, {1'b0, cycle_active}, 2'b00);
        chk({nm, " end dsack_n"}, v.hold, dsack_n, 2'b11);
        chk({nm, " end berr_n"}, v.hold, {1'b0, berr_n}, 2'b01);
        chk({nm, " end vector_fetched"}, v.hold, {1'b0, vector_fetched}, {1'b0, vf_exp});
        ext_ack = 1'b0;
    endtask

    initial begin
        vec_t v;
        int gap;

        tbl[0]  = '{4'd1,  2'd2, 3,  0,  1,  2'b01, 1'b0};
        tbl[1]  = '{4'd1,  2'd2, 3,  0,  1,  2'b01, 1'b0};
        tbl[2]  = '{4'd1,  2'd2, 3,  0,  1,  2'b01, 1'b0};
        tbl[3]  = '{4'd0,  2'd2, 3,  0,  99, 2'b11, 1'b1};
        tbl[4]  = '{4'd1,  2'd2, 3,  0,  1,  2'b01, 1'b0};
        tbl[5]  = '{4'd1,  2'd3, 2,  0,  1,  2'b00, 1'b0};
        tbl[6]  = '{4'd3,  2'd1, 8,  0,  6,  2'b10, 1'b0};
        tbl[7]  = '{4'd3,  2'd0, 2,  0,  99, 2'b11, 1'b1};
        tbl[8]  = '{4'd2,  2'd3, 13, 10, 10, 2'b00, 1'b0};
        tbl[9]  = '{4'd4,  2'd2, 4,  0,  8,  2'b01, 1'b0};
        tbl[10] = '{4'd4,  2'd2, 10, 0,  8,  2'b01, 1'b0};
        tbl[11] = '{4'd7,  2'd3, 17, 0,  16, 2'b00, 1'b0};
        tbl[12] = '{4'd6,  2'd1, 5,  9,  9,  2'b10, 1'b0};
        tbl[13] = '{4'd11, 2'd1, 4,  1,  1,  2'b10, 1'b0};

        reset        = 1'b0;
        as           = 1'b0;
        device_index = 4'd0;
        port_width   = 2'd0;
        ext_ack      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset dsack_n", 0, dsack_n, 2'b11);
        chk("reset berr_n", 0, {1'b0, berr_n}, 2'b01);
        chk("reset vector_fetched", 0, {1'b0, vector_fetched}, 2'b00);
        chk("reset active", 0, {1'b0, cycle_active}, 2'b00);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 14; i++) begin
            run_cycle($sformatf("tbl%0d", i), tbl[i]);
            $display("tbl%0d dev=%0d pw=%0d hold=%0d vf=%0b checks=%0d errors=%0d",
                     i, tbl[i].dev, tbl[i].pw, tbl[i].hold, vf_exp, checks, errors);
        end

        for (int i = 0; i < 40; i++) begin
            v.dev   = 4'($urandom_range(0, 15));
            v.pw    = 2'($urandom_range(0, 3));
            v.err   = (v.dev == 4'd0) || (v.pw == 2'd0);
            v.ext_d = EXT_P[v.dev] ? $urandom_range(1, 12) : 0;
            v.ack_e = EXT_P[v.dev] ? v.ext_d : ws_of(v.dev) + 1;
            v.hold  = v.err ? $urandom_range(1, 4) : $urandom_range(1, v.ack_e + 4);
            v.ds    = code_of(v.pw);
            run_cycle($sformatf("rnd%0d", i), v);
            $display("rnd%0d dev=%0d pw=%0d hold=%0d ack=%0d err=%0b checks=%0d errors=%0d",
                     i, v.dev, v.pw, v.hold, v.ack_e, v.err, checks, errors);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clock);
                #1;
                chk("gap active", g, {1'b0, cycle_active}, 2'b00);
            end
        end

        // Reset asserted while a cycle is acknowledged and as is still high.
        as           = 1'b1;
        device_index = 4'd1;
        port_width   = 2'd2;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("pre-reset dsack_n", 1, dsack_n, 2'b01);
        reset = 1'b0;
        @(posedge clock);
        #1;
        vf_exp   = 1'b0;
        vcnt_exp = 0;
        chk("mid-reset dsack_n", 0, dsack_n, 2'b11);
        chk("mid-reset active", 0, {1'b0, cycle_active}, 2'b00);
        chk("mid-reset vector_fetched", 0, {1'b0, vector_fetched}, 2'b00);
        reset = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge clock);
            #1;
            chk("post-reset as-high active", e, {1'b0, cycle_active}, 2'b00);
            chk("post-reset as-high dsack_n", e, dsack_n, 2'b11);
        end
        $display("reset-in-ACK sequence checks=%0d errors=%0d", checks, errors);
        as = 1'b0;
        @(posedge clock);
        #1;
        run_cycle("post-reset cycle", tbl[6]);
        run_cycle("post-reset word", tbl[0]);
        $display("post-reset cycles vf=%0b checks=%0d errors=%0d", vf_exp, checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
